q56_requantizer: RTL



---
 rtl/q56_pkg.sv | 36 +++
 rtl/q56_requantizer_if.sv | 31 +++
 rtl/q56_sat_cnt.sv | 28 ++
 rtl/q56_requantizer.sv | 109 ++++++++++
 4 files changed

// File: rtl/q56_pkg.sv
// q56_pkg: shared Q5.6 operand-format definitions for the neuron datapath.
// Holds the Q5.6 width/limit constants, the q56_t type and a saturating
// narrowing helper that also reports whether clipping occurred.
package q56_pkg;

  localparam int Q56_W    = 12;
  localparam int Q56_FRAC = 6;

  typedef logic signed [Q56_W-1:0] q56_t;

  localparam q56_t Q56_MAX = 12'sh7FF;
  localparam q56_t Q56_MIN = 12'sh800;

  // Saturated value plus the flag telling whether clipping happened.
  typedef struct packed {
    logic ovf;
    q56_t val;
  } q56_sat_t;

  // Clip any sign-extended value into the Q5.6 range.
  function automatic q56_sat_t q56_sat(input logic signed [63:0] v);
    q56_sat_t r;
    if (v > 64'sd2047) begin
      r.ovf = 1'b1;
      r.val = Q56_MAX;
    end else if (v < -64'sd2048) begin
      r.ovf = 1'b1;
      r.val = Q56_MIN;
    end else begin
      r.ovf = 1'b0;
      r.val = q56_t'(v[Q56_W-1:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/q56_requantizer_if.sv
// q56_requantizer_if: sample stream in, Q5.6 stream out, saturation counter.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; a producer holds valid and data stable until that transfer, and
// ready may depend combinationally on the consumer's ready but never on valid.
interface q56_requantizer_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 12,
  parameter int CNT_W = 16
);
  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sat;
  logic [CNT_W-1:0]        sat_count;
  logic                    sat_clr;

  // The requantizer side.
  modport slave (
    input  in_data, in_valid, out_ready, sat_clr,
    output in_ready, out_data, out_valid, out_sat, sat_count
  );

  // The environment side: upstream producer plus downstream consumer.
  modport master (
    output in_data, in_valid, out_ready, sat_clr,
    input  in_ready, out_data, out_valid, out_sat, sat_count
  );
endinterface

// File: rtl/q56_sat_cnt.sv
// q56_sat_cnt: saturating event counter with synchronous clear.
// Sticks at all-ones instead of wrapping; clear has priority over increment.
module q56_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count events, hold at the top value, clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/q56_requantizer.sv
// q56_requantizer: narrows a wide signed fixed-point sum (default Q13.12)
// to Q5.6 through a two-stage valid/ready pipeline: stage 1 shifts (and
// optionally rounds), stage 2 saturates. Saturated outputs accepted
// downstream are counted.
// Build option: define ROUND_NEAREST_EN for round-half-up; otherwise the
// shift truncates toward -inf.
module q56_requantizer
  import q56_pkg::*;
#(
  parameter int IN_W     = 26,
  parameter int IN_FRAC  = 12,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 6,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  q56_requantizer_if.slave    bus
);

  localparam int SH  = IN_FRAC - OUT_FRAC;
  localparam int S1W = IN_W + 1 - SH;

  logic                    s1_valid_q;
  logic signed [S1W-1:0]   s1_data_q, s1_data_d;
  logic                    out_valid_q, out_sat_q, out_sat_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    s1_load_w, s2_load_w;
  logic signed [IN_W:0]    ext_w, rnd_w;

  // A stage advances when it is empty or the stage after it advances.
  assign s2_load_w = !out_valid_q || bus.out_ready;
  assign s1_load_w = !s1_valid_q || s2_load_w;

  // One guard bit keeps the rounding add from overflowing.
  assign ext_w = {bus.in_data[IN_W-1], bus.in_data};

`ifdef ROUND_NEAREST_EN
  localparam logic [IN_W:0] RND_C =
    (SH > 0) ? ((IN_W+1)'(1) << ((SH > 0) ? (SH - 1) : 0)) : '0;
  assign rnd_w = ext_w + $signed(RND_C);
`else
  assign rnd_w = ext_w;
`endif

  assign s1_data_d = S1W'(rnd_w >>> SH);

  // Stage 1: capture the shifted value whenever the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (s1_load_w) begin
      s1_valid_q <= bus.in_valid;
      s1_data_q  <= s1_data_d;
    end
  end

  // Saturation: the shared Q5.6 helper for the native width, a generic
  // range clip for any other output width.
  if (OUT_W == Q56_W) begin : g_q56
    q56_sat_t sat_r_w;
    assign sat_r_w    = q56_sat(64'(s1_data_q));
    assign out_data_d = sat_r_w.val;
    assign out_sat_d  = sat_r_w.ovf;
  end else begin : g_generic
    localparam logic signed [S1W-1:0] SAT_HI = S1W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [S1W-1:0] SAT_LO = S1W'(-(2 ** (OUT_W - 1)));
    // Clip the stage-1 value into the output range.
    always_comb begin
      out_data_d = s1_data_q[OUT_W-1:0];
      out_sat_d  = 1'b0;
      if (s1_data_q > SAT_HI) begin
        out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
        out_sat_d  = 1'b1;
      end else if (s1_data_q < SAT_LO) begin
        out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
        out_sat_d  = 1'b1;
      end
    end
  end

  // Stage 2: register the saturated result; hold it while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (s2_load_w) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  q56_sat_cnt #(.W(CNT_W)) u_sat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.sat_clr),
    .inc_i   (out_valid_q && bus.out_ready && out_sat_q),
    .count_o (bus.sat_count)
  );

  assign bus.in_ready  = s1_load_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule
